// File: rtl/uart_tx_periph.sv
// ----------------------------------------------------------------------------
// uart_tx_periph
//   Memory-mapped 8N1 UART transmitter. The CPU pushes bytes into a TX FIFO
//   through the DATA register and polls STATUS; a serializer drains the FIFO
//   onto o_tx at DIV clock cycles per bit.
//
// Register map (i_addr[3:2]):
//   0 DATA   : write with mask[0] pushes di[7:0]; reads 0
//   1 STATUS : {16'b0, count[7:0], 4'b0, overflow, empty, full, busy}
//              write with mask[0] and di[3] clears the sticky overflow flag
//   2 DIV    : 16-bit bit period, byte lanes 0/1 individually writable
//   3 -      : reserved, reads 0, writes ignored
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_sel      chip select from the address decoder
//   i_addr     byte address, only [3:2] decoded
//   i_di       write data
//   i_mask     byte-lane write enables, lane 0 = i_di[7:0]
//   i_we       write enable, qualified by i_sel
//   o_do       combinational read data, 0 when not selected
//   o_tx       serial line, idle high
//   o_idle_irq high when FIFO empty and serializer idle (registered)
// ----------------------------------------------------------------------------
module uart_tx_periph #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_RESET = 868
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sel,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_di,
  input  logic [3:0]  i_mask,
  input  logic        i_we,
  output logic [31:0] o_do,
  output logic        o_tx,
  output logic        o_idle_irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [15:0]     r_div;
  logic [15:0]     r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_idle;

  logic            w_empty;
  logic            w_full;
  logic            w_busy;
  logic            w_wr;
  logic [1:0]      w_reg;
  logic            w_push;
  logic            w_push_ok;
  logic            w_pop;
  logic            w_ovf_clr;
  logic [15:0]     w_period;
  logic [15:0]     w_reload;
  logic            w_tick;
  logic            w_load;
  logic            w_shift_en;
  logic            w_tx_next;
  logic            w_unused;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign w_wr      = i_sel && i_we;
  assign w_reg     = i_addr[3:2];
  assign w_push    = w_wr && (w_reg == 2'd0) && i_mask[0];
  assign w_ovf_clr = w_wr && (w_reg == 2'd1) && i_mask[0] && i_di[3];

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_busy    = (r_state != S_IDLE);

  // A push into a full FIFO still lands when the serializer pops that cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);

  assign w_unused  = &{1'b0, i_addr[31:4], i_addr[1:0], i_di[31:16], i_mask[3:2]};

  // --------------------------------------------------------------------------
  // Bit timing: a DIV of 0 behaves like 1. The period counter counts down
  // from P-1; DIV is only sampled on reload so a running bit keeps its length.
  // --------------------------------------------------------------------------
  assign w_period = (r_div == '0) ? 16'd1 : r_div;
  assign w_reload = w_period - 16'd1;
  assign w_tick   = (r_cnt == '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_START;
      S_START: if (w_tick) w_next = S_DATA;
      S_DATA:  if (w_tick && (r_bit == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_tick) w_next = w_empty ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_pop      = 1'b0;
    w_load     = 1'b0;
    w_shift_en = 1'b0;
    w_tx_next  = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        w_load    = w_tick;
      end
      S_DATA: begin
        w_tx_next  = r_shift[0];
        w_load     = w_tick;
        w_shift_en = w_tick;
      end
      S_STOP: begin
        w_tx_next = 1'b1;
        w_load    = w_tick;
        // Back-to-back frames: the next byte is popped at the end of STOP.
        w_pop     = w_tick && !w_empty;
      end
      default: w_tx_next = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Serializer datapath. o_tx is registered from the state, so it lags the
  // state by one cycle; every bit still lasts exactly P cycles.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_idle  <= 1'b1;
    end else begin
      r_tx   <= w_tx_next;
      r_idle <= w_empty && (r_state == S_IDLE);

      if (w_load)       r_cnt <= w_reload;
      else if (!w_tick) r_cnt <= r_cnt - 16'd1;

      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
        r_bit   <= '0;
      end else if (w_shift_en) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_di[7:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;

      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_ovf_clr)             r_ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // DIV register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div <= 16'(DIV_RESET);
    end else if (w_wr && (w_reg == 2'd2)) begin
      if (i_mask[0]) r_div[7:0]  <= i_di[7:0];
      if (i_mask[1]) r_div[15:8] <= i_di[15:8];
    end
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    o_do = '0;
    if (i_sel) begin
      unique case (w_reg)
        2'd1:    o_do = {16'h0000, 8'(r_count), 4'h0, r_ovf, w_empty, w_full, w_busy};
        2'd2:    o_do = {16'h0000, r_div};
        default: o_do = '0;
      endcase
    end
  end

  assign o_tx       = r_tx;
  assign o_idle_irq = r_idle;

endmodule
